// File: rtl/i2c_axi_cmd_frontend.sv
`default_nettype none
// ============================================================================
// i2c_axi_cmd_frontend - AXI4-Lite byte accesses to 24-bit I2C bridge commands
// Rev 1.0
// ============================================================================
module i2c_axi_cmd_frontend #(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [23:0]       addr_data_out,
  output logic              valid_addr_data_out,
  output logic              I2C_trigger,
  input  logic              valid_data_ack,
  input  logic              valid_data_ack_valid,
  input  logic [7:0]        rdata_out,
  input  logic              rdata_out_valid,
  input  logic              PENDING_WR,
  input  logic              PENDING_RD
);

  localparam int                 c_cnt_w     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]         c_resp_okay = 2'b00;
  localparam logic [1:0]         c_resp_slv  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_TRIG    = 3'd2,
    ST_WAIT_WR = 3'd3,
    ST_WAIT_RD = 3'd4,
    ST_BRESP   = 3'd5,
    ST_RRESP   = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic                 run_q, run_d;
  logic                 aw_held_q, aw_held_d;
  logic [14:0]          aw_addr_q, aw_addr_d;
  logic                 w_held_q, w_held_d;
  logic [7:0]           w_data_q, w_data_d;
  logic                 w_strb0_q, w_strb0_d;
  logic                 ar_held_q, ar_held_d;
  logic [14:0]          ar_addr_q, ar_addr_d;
  logic                 rd_q, rd_d;
  logic [23:0]          cmd_q, cmd_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic [1:0]           bresp_q, bresp_d;
  logic [1:0]           rresp_q, rresp_d;
  logic [7:0]           rdata_q, rdata_d;

  logic w_idle;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_ar_hs;
  logic unused_inputs;

  // run_q keeps the ready outputs low while resetn is asserted
  assign w_idle        = (state_q == ST_IDLE) && run_q;
  assign s_axi_awready = w_idle && !aw_held_q;
  assign s_axi_wready  = w_idle && !w_held_q;
  assign s_axi_arready = w_idle && !ar_held_q;
  assign w_aw_hs       = s_axi_awvalid && s_axi_awready;
  assign w_w_hs        = s_axi_wvalid && s_axi_wready;
  assign w_ar_hs       = s_axi_arvalid && s_axi_arready;

  assign s_axi_bvalid        = (state_q == ST_BRESP);
  assign s_axi_bresp         = bresp_q;
  assign s_axi_rvalid        = (state_q == ST_RRESP);
  assign s_axi_rresp         = rresp_q;
  assign s_axi_rdata         = {24'h0, rdata_q};
  assign addr_data_out       = cmd_q;
  assign valid_addr_data_out = (state_q == ST_ISSUE);
  assign I2C_trigger         = (state_q == ST_TRIG);

  assign unused_inputs = ^{s_axi_awaddr, s_axi_araddr, s_axi_wdata[31:8], s_axi_wstrb[3:1]};

  always_comb begin
    state_d   = state_q;
    run_d     = 1'b1;
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb0_d = w_strb0_q;
    ar_held_d = ar_held_q;
    ar_addr_d = ar_addr_q;
    rd_d      = rd_q;
    cmd_d     = cmd_q;
    cnt_d     = cnt_q;
    bresp_d   = bresp_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;

    if (w_aw_hs) begin
      aw_held_d = 1'b1;
      aw_addr_d = s_axi_awaddr[14:0];
    end
    if (w_w_hs) begin
      w_held_d  = 1'b1;
      w_data_d  = s_axi_wdata[7:0];
      w_strb0_d = s_axi_wstrb[0];
    end
    if (w_ar_hs) begin
      ar_held_d = 1'b1;
      ar_addr_d = s_axi_araddr[14:0];
    end

    case (state_q)
      ST_IDLE: begin
        // writes win over a held read; nothing leaves while the core is busy
        if (!PENDING_WR && !PENDING_RD) begin
          if (aw_held_q && w_held_q) begin
            if (w_strb0_q) begin
              state_d = ST_ISSUE;
              rd_d    = 1'b0;
              cmd_d   = {aw_addr_q[14:8], 1'b0, aw_addr_q[7:0], w_data_q};
            end else begin
              state_d = ST_BRESP;
              bresp_d = c_resp_slv;
            end
          end else if (ar_held_q) begin
            state_d = ST_ISSUE;
            rd_d    = 1'b1;
            cmd_d   = {ar_addr_q[14:8], 1'b1, ar_addr_q[7:0], 8'h00};
          end
        end
      end
      ST_ISSUE: state_d = ST_TRIG;
      ST_TRIG: begin
        state_d = rd_q ? ST_WAIT_RD : ST_WAIT_WR;
        cnt_d   = '0;
      end
      ST_WAIT_WR: begin
        if (valid_data_ack_valid) begin
          state_d = ST_BRESP;
          bresp_d = valid_data_ack ? c_resp_okay : c_resp_slv;
        end else if (cnt_q == c_cnt_last) begin
          state_d = ST_BRESP;
          bresp_d = c_resp_slv;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_RD: begin
        // returned data takes precedence over a simultaneous NACK
        if (rdata_out_valid) begin
          state_d = ST_RRESP;
          rresp_d = c_resp_okay;
          rdata_d = rdata_out;
        end else if ((valid_data_ack_valid && !valid_data_ack) || (cnt_q == c_cnt_last)) begin
          state_d = ST_RRESP;
          rresp_d = c_resp_slv;
          rdata_d = 8'h00;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BRESP: begin
        if (s_axi_bready) begin
          state_d   = ST_IDLE;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      ST_RRESP: begin
        if (s_axi_rready) begin
          state_d   = ST_IDLE;
          ar_held_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      run_q     <= 1'b0;
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb0_q <= 1'b0;
      ar_held_q <= 1'b0;
      ar_addr_q <= '0;
      rd_q      <= 1'b0;
      cmd_q     <= '0;
      cnt_q     <= '0;
      bresp_q   <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb0_q <= w_strb0_d;
      ar_held_q <= ar_held_d;
      ar_addr_q <= ar_addr_d;
      rd_q      <= rd_d;
      cmd_q     <= cmd_d;
      cnt_q     <= cnt_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_axi_cmd_frontend.sv
`default_nettype none
// ============================================================================
// tb_i2c_axi_cmd_frontend - directed and randomized checks against a spec model
// Rev 1.0
// ============================================================================
module tb_i2c_axi_cmd_frontend;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [15:0] s_axi_awaddr, s_axi_araddr;
  logic        s_axi_awvalid, s_axi_wvalid, s_axi_bready, s_axi_arvalid, s_axi_rready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        valid_data_ack, valid_data_ack_valid, rdata_out_valid, PENDING_WR, PENDING_RD;
  logic [7:0]  rdata_out;

  logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic [31:0] s_axi_rdata;
  logic [23:0] addr_data_out;
  logic        valid_addr_data_out, I2C_trigger;

  // second instance with a short timeout, sharing every input
  logic        unused_to_awready, unused_to_wready, unused_to_bvalid, unused_to_arready;
  logic [1:0]  unused_to_bresp;
  logic [23:0] unused_to_cmd;
  logic        unused_to_valid, unused_to_trig;
  logic        to_rvalid;
  logic [1:0]  to_rresp;
  logic [31:0] to_rdata;

  i2c_axi_cmd_frontend #(.ADDR_W(16)) dut (
    .clk(clk), .resetn(resetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .addr_data_out(addr_data_out), .valid_addr_data_out(valid_addr_data_out),
    .I2C_trigger(I2C_trigger), .valid_data_ack(valid_data_ack),
    .valid_data_ack_valid(valid_data_ack_valid), .rdata_out(rdata_out),
    .rdata_out_valid(rdata_out_valid), .PENDING_WR(PENDING_WR), .PENDING_RD(PENDING_RD)
  );

  i2c_axi_cmd_frontend #(.ADDR_W(16), .TIMEOUT_CYCLES(16)) dut_to (
    .clk(clk), .resetn(resetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(unused_to_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(unused_to_wready), .s_axi_bresp(unused_to_bresp), .s_axi_bvalid(unused_to_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(unused_to_arready), .s_axi_rdata(to_rdata), .s_axi_rresp(to_rresp),
    .s_axi_rvalid(to_rvalid), .s_axi_rready(s_axi_rready),
    .addr_data_out(unused_to_cmd), .valid_addr_data_out(unused_to_valid),
    .I2C_trigger(unused_to_trig), .valid_data_ack(valid_data_ack),
    .valid_data_ack_valid(valid_data_ack_valid), .rdata_out(rdata_out),
    .rdata_out_valid(rdata_out_valid), .PENDING_WR(PENDING_WR), .PENDING_RD(PENDING_RD)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [23:0] last_cmd = 24'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Command word from the address map: device = addr[14:8], register = addr[7:0]
  function automatic logic [23:0] model_cmd(input bit rd, input logic [15:0] a, input logic [7:0] d);
    int dev, regi, cmd;
    dev  = (int'(a) / 256) % 128;
    regi = int'(a) % 256;
    cmd  = dev * 131072 + (rd ? 65536 : 0) + regi * 256 + (rd ? 0 : int'(d));
    return 24'(cmd);
  endfunction

  // kind: write 0=ACK 1=NACK; read 0=data 1=NACK 2=data+NACK same cycle
  function automatic logic [9:0] model_resp(input bit rd, input logic [3:0] strb, input int kind,
                                            input logic [7:0] b);
    if (!rd) return (!strb[0] || kind != 0) ? {2'b10, 8'h00} : {2'b00, 8'h00};
    if (kind == 1) return {2'b10, 8'h00};
    return {2'b00, b};
  endfunction

  task automatic send_aw(input logic [15:0] a);
    int n = 0;
    s_axi_awaddr  = a;
    s_axi_awvalid = 1'b1;
    while (!s_axi_awready && n < 200) begin @(negedge clk); n++; end
    check_eq("aw_accept_wait", 32'(n < 200), 1);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [7:0] d, input logic [3:0] strb);
    int n = 0;
    s_axi_wdata       = $urandom;
    s_axi_wdata[7:0]  = d;
    s_axi_wstrb       = strb;
    s_axi_wvalid      = 1'b1;
    while (!s_axi_wready && n < 200) begin @(negedge clk); n++; end
    check_eq("w_accept_wait", 32'(n < 200), 1);
    @(negedge clk);
    s_axi_wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [15:0] a);
    int n = 0;
    s_axi_araddr  = a;
    s_axi_arvalid = 1'b1;
    while (!s_axi_arready && n < 200) begin @(negedge clk); n++; end
    check_eq("ar_accept_wait", 32'(n < 200), 1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
  endtask

  // Called at a negedge after the request channels were accepted.
  task automatic finish_txn(input bit rd, input logic [15:0] a, input logic [7:0] wd,
                            input logic [3:0] strb, input int kind, input logic [7:0] b,
                            input int lat, input int exp_wait, input int rdy_dly);
    int         n;
    bit         seen;
    logic [9:0] exp;
    exp = model_resp(rd, strb, kind, b);
    if (!rd && !strb[0]) begin
      n = 0; seen = 0;
      while (!s_axi_bvalid && n < 50) begin
        seen |= valid_addr_data_out | I2C_trigger;
        @(negedge clk); n++;
      end
      check_eq("nostrb_bvalid_wait", 32'(n < 50), 1);
      check_eq("nostrb_no_cmd", 32'(seen), 0);
      check_eq("nostrb_cmd_hold", addr_data_out, last_cmd);
    end else begin
      n = 0;
      while (!valid_addr_data_out && n < 200) begin @(negedge clk); n++; end
      check_eq("cmd_wait", 32'(n < 200), 1);
      if (exp_wait >= 0) check_eq("cmd_latency", n, exp_wait);
      last_cmd = model_cmd(rd, a, wd);
      check_eq("cmd_word", addr_data_out, last_cmd);
      check_eq("trig_with_valid", I2C_trigger, 0);
      @(negedge clk);
      check_eq("trig_pulse", {valid_addr_data_out, I2C_trigger}, 2'b01);
      @(negedge clk);
      seen = 0;
      repeat (lat - 1) begin
        seen |= s_axi_bvalid | s_axi_rvalid | valid_addr_data_out | I2C_trigger;
        @(negedge clk);
      end
      seen |= s_axi_bvalid | s_axi_rvalid | valid_addr_data_out | I2C_trigger;
      check_eq("quiet_while_waiting", 32'(seen), 0);
      rdata_out = b;
      if (!rd) begin
        valid_data_ack_valid = 1'b1;
        valid_data_ack       = (kind == 0);
      end else begin
        rdata_out_valid      = (kind != 1);
        valid_data_ack_valid = (kind != 0);
        valid_data_ack       = 1'b0;
      end
      @(negedge clk);
      valid_data_ack_valid = 1'b0;
      rdata_out_valid      = 1'b0;
      rdata_out            = $urandom;
    end
    check_eq("resp_valid", rd ? s_axi_rvalid : s_axi_bvalid, 1);
    if (rd) begin
      check_eq("rresp", s_axi_rresp, exp[9:8]);
      check_eq("rdata", s_axi_rdata, {24'h0, exp[7:0]});
    end else begin
      check_eq("bresp", s_axi_bresp, exp[9:8]);
    end
    seen = 0;
    repeat (rdy_dly) begin
      @(negedge clk);
      seen |= !(rd ? s_axi_rvalid : s_axi_bvalid);
    end
    check_eq("resp_hold", 32'(seen), 0);
    if (rd) s_axi_rready = 1'b1; else s_axi_bready = 1'b1;
    @(negedge clk);
    s_axi_rready = 1'b0;
    s_axi_bready = 1'b0;
    check_eq("resp_done", {s_axi_bvalid, s_axi_rvalid}, 2'b00);
    check_eq("idle_ready", rd ? s_axi_arready : s_axi_awready, 1);
    check_eq("cmd_hold", addr_data_out, last_cmd);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_awready", s_axi_awready, 0);
    check_eq("rst_wready", s_axi_wready, 0);
    check_eq("rst_arready", s_axi_arready, 0);
    check_eq("rst_bvalid", s_axi_bvalid, 0);
    check_eq("rst_rvalid", s_axi_rvalid, 0);
    check_eq("rst_bresp", s_axi_bresp, 0);
    check_eq("rst_rresp", s_axi_rresp, 0);
    check_eq("rst_rdata", s_axi_rdata, 0);
    check_eq("rst_cmd", addr_data_out, 0);
    check_eq("rst_strobes", {valid_addr_data_out, I2C_trigger}, 2'b00);
  endtask

  initial begin
    int          n, p, kind, lat, rdy;
    bit          rd, seen;
    logic [15:0] a;
    logic [7:0]  wd, b;
    logic [3:0]  strb;

    resetn = 1'b0;
    s_axi_awaddr = '0; s_axi_araddr = '0; s_axi_awvalid = 0; s_axi_wvalid = 0;
    s_axi_arvalid = 0; s_axi_bready = 0; s_axi_rready = 0; s_axi_wdata = '0; s_axi_wstrb = '0;
    valid_data_ack = 0; valid_data_ack_valid = 0; rdata_out = '0; rdata_out_valid = 0;
    PENDING_WR = 0; PENDING_RD = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    resetn = 1'b1;
    @(negedge clk);
    check_eq("init_ready", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

    // Silent core: short-timeout instance errors after 16 wait cycles
    send_ar(16'h1234);
    n = 0;
    while (!valid_addr_data_out && n < 20) begin @(negedge clk); n++; end
    check_eq("to_cmd_latency", n, 1);
    @(negedge clk);
    check_eq("to_trig", I2C_trigger, 1);
    n = 0;
    while (!to_rvalid && n < 40) begin @(negedge clk); n++; end
    check_eq("to_wait_cycles", n, 17);
    check_eq("to_rresp", to_rresp, 2'b10);
    check_eq("to_rdata", to_rdata, 0);
    s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_rready = 1'b0;
    check_eq("to_rvalid_done", to_rvalid, 0);
    check_eq("main_still_waiting", s_axi_rvalid, 0);

    // Reset while the main instance sits in WAIT_RD
    resetn = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    resetn          = 1'b1;
    rdata_out_valid = 1'b1;
    rdata_out       = 8'h77;
    @(negedge clk);
    rdata_out_valid = 1'b0;
    check_eq("post_rst_ready", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
    seen = 0;
    repeat (3) begin seen |= s_axi_rvalid | s_axi_bvalid; @(negedge clk); end
    check_eq("post_rst_no_resp", 32'(seen), 0);
    last_cmd = 24'h0;
    send_ar(16'h0A41);
    finish_txn(1, 16'h0A41, 8'h00, 4'h0, 0, 8'hC7, 4, 1, 0);

    // Best-case write, ACK 20 cycles after the trigger
    fork
      send_aw(16'h5010);
      send_w(8'hA5, 4'h1);
    join
    finish_txn(0, 16'h5010, 8'hA5, 4'h1, 0, 8'h00, 20, 1, 1);
    send_ar(16'h2203);
    finish_txn(1, 16'h2203, 8'h00, 4'h0, 0, 8'h3C, 6, 1, 0);
    fork
      send_aw(16'h1F22);
      send_w(8'h5B, 4'hF);
    join
    finish_txn(0, 16'h1F22, 8'h5B, 4'hF, 1, 8'h00, 3, 1, 0);
    send_ar(16'h7E80);
    finish_txn(1, 16'h7E80, 8'h00, 4'h0, 1, 8'h5A, 2, 1, 2);

    // W five cycles ahead of AW while the core reports busy for ten cycles
    PENDING_WR = 1'b1;
    send_w(8'h96, 4'h1);
    check_eq("wready_drop", s_axi_wready, 0);
    repeat (4) @(negedge clk);
    send_aw(16'h3344);
    check_eq("awready_drop", s_axi_awready, 0);
    seen = 0;
    repeat (4) begin seen |= valid_addr_data_out; @(negedge clk); end
    seen |= valid_addr_data_out;
    check_eq("pending_no_cmd", 32'(seen), 0);
    PENDING_WR = 1'b0;
    finish_txn(0, 16'h3344, 8'h96, 4'h1, 0, 8'h00, 5, 1, 0);

    // Write and read offered together: write goes first
    fork
      send_aw(16'h6601);
      send_w(8'h11, 4'h1);
      send_ar(16'h4502);
    join
    finish_txn(0, 16'h6601, 8'h11, 4'h1, 0, 8'h00, 3, 1, 0);
    finish_txn(1, 16'h4502, 8'h00, 4'h0, 2, 8'hE4, 3, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      rd   = 1'($urandom_range(0, 1));
      a    = 16'($urandom);
      wd   = 8'($urandom);
      strb = 4'($urandom);
      if ($urandom_range(0, 3) != 0) strb[0] = 1'b1;
      kind = rd ? $urandom_range(0, 2) : $urandom_range(0, 1);
      b    = 8'($urandom);
      lat  = $urandom_range(1, 30);
      p    = $urandom_range(0, 3);
      rdy  = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) begin
        valid_data_ack_valid = 1'b1;
        valid_data_ack       = 1'($urandom);
        rdata_out_valid      = 1'($urandom);
        @(negedge clk);
        valid_data_ack_valid = 1'b0;
        rdata_out_valid      = 1'b0;
        check_eq("stray_ignored", {s_axi_bvalid, s_axi_rvalid, valid_addr_data_out}, 3'b000);
      end
      if (p > 0) begin
        if ($urandom_range(0, 1) != 0) PENDING_WR = 1'b1; else PENDING_RD = 1'b1;
      end
      if (rd) begin
        send_ar(a);
      end else begin
        fork
          send_aw(a);
          send_w(wd, strb);
        join
      end
      repeat (p) @(negedge clk);
      PENDING_WR = 1'b0;
      PENDING_RD = 1'b0;
      finish_txn(rd, a, wd, strb, kind, b, lat, 1, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
